proc_ctrl: RTL

PROC_CTRL -- requirements
Module: proc_ctrl

---
 rtl/proc_pkg.sv | 19 +
 rtl/dec3to8.sv | 13 +
 rtl/proc_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared types and constants for the processor control unit and its decoders.
package proc_pkg;

    localparam int WORD_W = 9;
    localparam int NREG   = 8;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder for register selection.
// Purely combinational; no flow control.
module dec3to8 (
    input  logic [2:0] sel,
    output logic [7:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/proc_ctrl.sv
// Multi-cycle control FSM for a simple bus-based processor: fetches into IR on Run in T0.
// Done after 1 cycle (mv, mvi, reserved) or 3 cycles (add, sub); Run is ignored mid-instruction.
module proc_ctrl
    import proc_pkg::*;
(
    input  logic              Clock,
    input  logic              rst,
    input  logic              Run,
    input  logic [WORD_W-1:0] DIN,
    output logic [NREG-1:0]   Rout,
    output logic [NREG-1:0]   Rin,
    output logic              Gout,
    output logic              DINout,
    output logic              Ain,
    output logic              Gin,
    output logic              AddSub,
    output logic              Done
);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [2:0]        op;
    logic [NREG-1:0]   x_oh, y_oh;
    logic              is_alu;

    assign op     = ir_q[8:6];
    assign is_alu = (op == OP_ADD) || (op == OP_SUB);

    dec3to8 u_dec_x (
        .sel    (ir_q[5:3]),
        .onehot (x_oh)
    );

    dec3to8 u_dec_y (
        .sel    (ir_q[2:0]),
        .onehot (y_oh)
    );

    always_ff @(posedge Clock) begin
        state_q <= state_d;
        ir_q    <= ir_d;
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        if (!rst) begin
            state_d = T0;
            ir_d    = '0;
        end else begin
            case (state_q)
                T0: begin
                    if (Run) begin
                        ir_d    = DIN;
                        state_d = T1;
                    end
                end
                T1:      state_d = is_alu ? T2 : T0;
                T2:      state_d = T3;
                T3:      state_d = T0;
                default: state_d = T0;
            endcase
        end
    end

    // Outputs decode only state and IR; reset gates them because datapath
    // enables would otherwise override the datapath's own reset.
    always_comb begin
        Rout   = '0;
        Rin    = '0;
        Gout   = 1'b0;
        DINout = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        if (rst) begin
            case (state_q)
                T1: begin
                    case (op)
                        OP_MV: begin
                            Rout = y_oh;
                            Rin  = x_oh;
                            Done = 1'b1;
                        end
                        OP_MVI: begin
                            DINout = 1'b1;
                            Rin    = x_oh;
                            Done   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            Rout = x_oh;
                            Ain  = 1'b1;
                        end
                        default: Done = 1'b1;
                    endcase
                end
                T2: begin
                    Rout   = y_oh;
                    Gin    = 1'b1;
                    AddSub = (op == OP_SUB);
                end
                T3: begin
                    Gout = 1'b1;
                    Rin  = x_oh;
                    Done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
